// File: rtl/ofm_axi_write_master_pkg.sv
// Shared types and constants for the OFM AXI4 write master.
package ofm_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } ofm_wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BEAT_BYTES     = 64;
  localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/ofm_axi_write_master_if.sv
// OFM stream input plus AXI4 write channels, bundled for the write master.
// Every channel transfers on a rising edge where its valid and ready are both high;
// valid never waits on ready, and the payload is held while valid is high and ready low.
interface ofm_axi_write_master_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
);
  logic                    axis_slv_tvalid;
  logic                    axis_slv_tready;
  logic [DATA_WIDTH-1:0]   axis_slv_tdata;

  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;

  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;

  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [1:0]              m_axi_bresp;

  modport master (
    input  axis_slv_tvalid, axis_slv_tdata,
    output axis_slv_tready,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready
  );

  modport slave (
    output axis_slv_tvalid, axis_slv_tdata,
    input  axis_slv_tready,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready
  );

endinterface

// File: rtl/ofm_axi_write_master_bresp.sv
// Counts bursts awaiting a write response and records any non-OKAY response.
module axi_bresp_tracker
  import ofm_wr_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aw_hs,
  input  logic       b_hs,
  input  logic [1:0] bresp,
  input  logic       clr_err,
  output logic       full,
  output logic       empty,
  output logic       err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             b_live;

  // Responses with nothing outstanding belong to a transfer abandoned by reset.
  assign b_live = b_hs && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (aw_hs && !b_live) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!aw_hs && b_live) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (clr_err) begin
      err_d = 1'b0;
    end else if (b_live && (bresp != AXI_RESP_OKAY)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign err   = err_q;

endmodule

// File: rtl/ofm_axi_write_master.sv
// Splits an OFM write request into 4 KB-safe INCR bursts and streams engine data onto the W channel.
module ofm_axi_write_master
  import ofm_wr_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  input  logic [ADDR_WIDTH-1:0] addr_offset,
  input  logic [63:0]           xfer_size,
  output logic                  done,
  output logic                  busy,
  output logic                  err,
  output ofm_wr_state_e         dbg_state,
  ofm_axi_write_master_if.master bus
);

  ofm_wr_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [57:0]           beats_left_q, beats_left_d;
  logic [8:0]            blen_q, blen_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;

  logic [ADDR_WIDTH-1:0] start_addr;
  logic [57:0]           room_beats, lim_beats;
  logic [8:0]            blen_calc;
  logic                  aw_hs, w_hs, b_hs, last_beat, accept;
  logic                  ot_full, ot_empty;
  logic                  unused_low_bits;

  assign start_addr      = addr_base + addr_offset;
  assign unused_low_bits = ^{xfer_size[5:0], start_addr[5:0]};
  assign accept          = (state_q == ST_IDLE) && req;

  // Beats remaining before the next 4 KB page boundary: always 1..64.
  always_comb begin
    room_beats = 58'(7'd64 - {1'b0, cur_addr_q[11:6]});
    lim_beats  = (beats_left_q < 58'(MAX_BURST_LEN)) ? beats_left_q : 58'(MAX_BURST_LEN);
    blen_calc  = (lim_beats < room_beats) ? lim_beats[8:0] : room_beats[8:0];
  end

  always_comb begin
    bus.m_axi_awvalid   = 1'b0;
    bus.m_axi_awaddr    = '0;
    bus.m_axi_awlen     = '0;
    bus.m_axi_awsize    = '0;
    bus.m_axi_awburst   = '0;
    bus.m_axi_wvalid    = 1'b0;
    bus.m_axi_wdata     = '0;
    bus.m_axi_wstrb     = '0;
    bus.m_axi_wlast     = 1'b0;
    bus.axis_slv_tready = 1'b0;
    bus.m_axi_bready    = 1'b1;
    last_beat           = (beat_cnt_q == (blen_q - 9'd1));
    if ((state_q == ST_ADDR) && !ot_full) begin
      bus.m_axi_awvalid = 1'b1;
      bus.m_axi_awaddr  = cur_addr_q;
      bus.m_axi_awlen   = 8'(blen_calc - 9'd1);
      bus.m_axi_awsize  = AXI_SIZE_64B;
      bus.m_axi_awburst = AXI_BURST_INCR;
    end
    // Unbuffered pass-through: a stream stall shows up directly as a W-channel gap.
    if (state_q == ST_DATA) begin
      bus.m_axi_wvalid    = bus.axis_slv_tvalid;
      bus.axis_slv_tready = bus.m_axi_wready;
      bus.m_axi_wdata     = bus.axis_slv_tdata;
      bus.m_axi_wstrb     = '1;
      bus.m_axi_wlast     = last_beat;
    end
  end

  assign aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
  assign w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
  assign b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    blen_d       = blen_q;
    beat_cnt_d   = beat_cnt_q;
    done         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          cur_addr_d   = {start_addr[ADDR_WIDTH-1:6], 6'b0};
          beats_left_d = xfer_size[63:6];
          beat_cnt_d   = '0;
          state_d      = (xfer_size[63:6] == '0) ? ST_DRAIN : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          cur_addr_d   = cur_addr_q + ADDR_WIDTH'({blen_calc, 6'b0});
          beats_left_d = beats_left_q - 58'(blen_calc);
          blen_d       = blen_calc;
          beat_cnt_d   = '0;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = (beats_left_q != '0) ? ST_ADDR : ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (ot_empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      blen_q       <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      blen_q       <= blen_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  axi_bresp_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_bresp_tracker (
    .clk    (clk),
    .rst    (rst),
    .aw_hs  (aw_hs),
    .b_hs   (b_hs),
    .bresp  (bus.m_axi_bresp),
    .clr_err(accept),
    .full   (ot_full),
    .empty  (ot_empty),
    .err    (err)
  );

endmodule
